// File: rtl/mult_arb_pkg.sv
// Shared types for the multiplier arbiter: FSM states, operand type and id-width helper.
// Pure declarations, no timing or flow-control behaviour of its own.
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ABORT,
    RESP
  } state_t;

  typedef logic [63:0] operand_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin pick: first requester after last_id (wrapping), combinational, zero latency.
// No backpressure; any_valid is low when nobody requests and winner then holds last_id.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic [ID_W-1:0] idx;

  // Scan from last_id+1 round to last_id itself, so the last winner has lowest priority.
  always_comb begin
    winner    = last_id;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_id) + i) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one start/done multiplier among NUM_REQ requesters; grant 1 cycle after request, response L+1 after grant.
// One op in flight: requesters hold req_valid until granted; a watchdog aborts ops whose done never arrives.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][63:0] req_mcand,
  input  logic [NUM_REQ-1:0][63:0] req_mplier,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_REQ-1:0]       resp_done,
  output logic [63:0]              resp_product,
  output logic                     resp_err,
  output logic                     mult_reset,
  output logic                     mult_start,
  output logic [63:0]              mult_mcand,
  output logic [63:0]              mult_mplier,
  input  logic [63:0]              mult_product,
  input  logic                     mult_done
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] id_q, last_id_q, winner;
  logic            any_valid;
  operand_t        mcand_q, mplier_q, prod_q;
  logic [WD_W-1:0] wdog_q;
  logic            wdog_exp;

  assign wdog_exp = (wdog_q == WD_W'(TIMEOUT - 1));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req_valid),
    .last_id   (last_id_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A done arriving on the watchdog's last cycle still counts as a normal completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (mult_done)     state_d = RESP;
        else if (wdog_exp) state_d = ABORT;
      end
      RESP:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_id starts at the top index so requester 0 wins first after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q      <= '0;
      last_id_q <= ID_W'(NUM_REQ - 1);
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      wdog_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            id_q     <= winner;
            mcand_q  <= req_mcand[winner];
            mplier_q <= req_mplier[winner];
          end
        end
        ISSUE: wdog_q <= '0;
        WAIT: begin
          if (mult_done) begin
            prod_q <= mult_product;
          end else if (!wdog_exp) begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        RESP, ABORT: last_id_q <= id_q;
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so no req_* input reaches an output combinationally.
  always_comb begin
    req_grant    = '0;
    resp_done    = '0;
    resp_product = '0;
    resp_err     = 1'b0;
    mult_reset   = 1'b1;
    mult_start   = 1'b0;
    mult_mcand   = '0;
    mult_mplier  = '0;
    case (state_q)
      ISSUE: begin
        req_grant[id_q] = 1'b1;
        mult_reset      = 1'b0;
        mult_start      = 1'b1;
        mult_mcand      = mcand_q;
        mult_mplier     = mplier_q;
      end
      WAIT: begin
        mult_reset  = 1'b0;
        mult_mcand  = mcand_q;
        mult_mplier = mplier_q;
      end
      RESP: begin
        resp_done[id_q] = 1'b1;
        resp_product    = prod_q;
      end
      ABORT: begin
        resp_done[id_q] = 1'b1;
        resp_err        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural L-cycle multiplier and a transaction-level scoreboard.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0][63:0] req_mcand;
  logic [N-1:0][63:0] req_mplier;
  logic [N-1:0]      req_grant;
  logic [N-1:0]      resp_done;
  logic [63:0]       resp_product;
  logic              resp_err;
  logic              mult_reset;
  logic              mult_start;
  logic [63:0]       mult_mcand;
  logic [63:0]       mult_mplier;
  logic [63:0]       mult_product;
  logic              mult_done;

  always #5 clock = ~clock;

  mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .req_grant    (req_grant),
    .resp_done    (resp_done),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .mult_reset   (mult_reset),
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_product (mult_product),
    .mult_done    (mult_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // multiplier model: mlat==0 means it never completes
  int          mlat, cnt;
  logic [63:0] ma, mb;
  logic        inj_done, spur_on_resp, keep_mode, rand_lat, seq_check;

  // scoreboard
  logic        idle_prev, resp_last, infl_busy, infl_err;
  int          last_served, infl_id, infl_lat, grant_cyc, prev_gid, n_resp;
  logic [63:0] infl_prod, last_prod;
  int          grant_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int qat(input int k);
    return (grant_q.size() > k) ? grant_q[k] : -1;
  endfunction

  task automatic model_reset();
    infl_busy   = 1'b0;
    last_served = N - 1;
    idle_prev   = 1'b1;
    resp_last   = 1'b0;
    cnt         = 0;
    prev_gid    = -1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_grant",  64'(req_grant),   64'd0);
    chk("rst_done",   64'(resp_done),   64'd0);
    chk("rst_err",    64'(resp_err),    64'd0);
    chk("rst_prod",   resp_product,     64'd0);
    chk("rst_start",  64'(mult_start),  64'd0);
    chk("rst_mcand",  mult_mcand,       64'd0);
    chk("rst_mplier", mult_mplier,      64'd0);
    chk("rst_mreset", 64'(mult_reset),  64'd1);
  endtask

  // One clock: advance multiplier model, then check grant/response against the scoreboard.
  task automatic step();
    logic exp_g, new_idle;
    int   gid, oid;
    @(posedge clock);
    #1;
    cyc++;
    if (mult_start) begin
      cnt = mlat;
      ma  = mult_mcand;
      mb  = mult_mplier;
    end else if (mult_reset) begin
      cnt = 0;
    end
    mult_done = 1'b0;
    if (!mult_start && cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mult_done    = 1'b1;
        mult_product = ma * mb;
      end
    end
    if (inj_done) begin
      mult_done    = 1'b1;
      mult_product = 64'hdead_beef;
    end

    exp_g = idle_prev && (req_valid != '0);
    chk("grant_when", 64'(req_grant != '0), 64'(exp_g));
    if (req_grant != '0) begin
      gid = rr_pick(req_valid, last_served);
      oid = -1;
      for (int k = N - 1; k >= 0; k--) if (req_grant[k]) oid = k;
      chk("grant_onehot", 64'($countones(req_grant)), 64'd1);
      chk("grant_id", 64'(oid), 64'(gid));
      chk("single_flight", 64'(infl_busy), 64'd0);
      if (seq_check && prev_gid >= 0) chk("rr_seq", 64'(oid), 64'((prev_gid + 1) % N));
      prev_gid = oid;
      grant_q.push_back(oid);
      infl_id   = (gid < 0) ? oid : gid;
      infl_busy = 1'b1;
      infl_prod = req_mcand[infl_id] * req_mplier[infl_id];
      infl_err  = (mlat == 0) || (mlat > TO);
      infl_lat  = infl_err ? TO + 1 : mlat + 1;
      grant_cyc = cyc;
      if (keep_mode) begin
        req_mcand[infl_id]  = rnd64();
        req_mplier[infl_id] = rnd64();
      end else begin
        req_valid[infl_id] = 1'b0;
      end
      if (rand_lat) mlat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
    end

    if (resp_done != '0) begin
      chk("resp_expected", 64'(infl_busy), 64'd1);
      chk("resp_id", 64'(resp_done), 64'(1 << infl_id));
      chk("resp_err", 64'(resp_err), 64'(infl_err));
      chk("resp_product", resp_product, infl_err ? 64'd0 : infl_prod);
      chk("resp_latency", 64'(cyc - grant_cyc), 64'(infl_lat));
      last_served = infl_id;
      infl_busy   = 1'b0;
      last_prod   = resp_product;
      n_resp++;
      if (spur_on_resp) begin
        mult_done    = 1'b1;
        mult_product = 64'hdead_beef;
      end
    end

    new_idle  = resp_last || (idle_prev && (req_grant == '0));
    resp_last = (resp_done != '0);
    idle_prev = new_idle;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((req_valid != '0 || infl_busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain", 64'({infl_busy, req_valid != '0}), 64'd0);
    step();
  endtask

  task automatic single(input int id, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp);
    req_mcand[id]  = a;
    req_mplier[id] = b;
    req_valid[id]  = 1'b1;
    run_until_idle(200);
    chk("dir_prod", last_prod, exp);
    chk("dir_id", 64'(last_served), 64'(id));
  endtask

  initial begin
    int n0, n;
    reset_n      = 1'b0;
    req_valid    = '0;
    req_mcand    = '0;
    req_mplier   = '0;
    mult_product = '0;
    mult_done    = 1'b0;
    inj_done     = 1'b0;
    spur_on_resp = 1'b0;
    keep_mode    = 1'b0;
    rand_lat     = 1'b0;
    seq_check    = 1'b0;
    mlat         = 8;
    n_resp       = 0;
    last_prod    = '0;
    ma           = '0;
    mb           = '0;
    model_reset();
    #1;
    chk_reset_vals();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // directed single requests
    single(0, 64'd3, 64'd5, 64'd15);
    single(1, 64'h1_0000_0000, 64'h8000_0000, 64'h8000_0000_0000_0000);
    single(3, 64'hffff_ffff_ffff_ffff, 64'd2, 64'hffff_ffff_ffff_fffe);

    // req1 and req3 with last served = 1
    single(1, 64'd6, 64'd7, 64'd42);
    grant_q.delete();
    req_mcand[1] = rnd64(); req_mplier[1] = rnd64();
    req_mcand[3] = rnd64(); req_mplier[3] = rnd64();
    req_valid = 4'b1010;
    run_until_idle(200);
    chk("rr_first", 64'(qat(0)), 64'd3);
    chk("rr_second", 64'(qat(1)), 64'd1);

    // all four requesting continuously
    for (int i = 0; i < N; i++) begin
      req_mcand[i]  = rnd64();
      req_mplier[i] = rnd64();
    end
    keep_mode = 1'b1;
    seq_check = 1'b1;
    prev_gid  = -1;
    n0 = n_resp;
    req_valid = '1;
    n = 0;
    while (n_resp < n0 + 10 && n < 400) begin
      step();
      n++;
    end
    chk("cont_count", 64'(n_resp - n0), 64'd10);
    keep_mode = 1'b0;
    run_until_idle(200);
    seq_check = 1'b0;

    // watchdog: stuck, done on last cycle, done one cycle too late
    mlat = 0;
    single(2, 64'd7, 64'd9, 64'd0);
    mlat = 8;
    single(2, 64'd7, 64'd9, 64'd63);
    mlat = TO;
    single(0, 64'd11, 64'd13, 64'd143);
    mlat = TO + 1;
    single(1, 64'd11, 64'd13, 64'd0);
    mlat = 8;

    // spurious done while idle and during the response cycle
    n0 = n_resp;
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    repeat (3) step();
    chk("spur_idle", 64'(n_resp), 64'(n0));
    spur_on_resp = 1'b1;
    single(3, 64'd4, 64'd4, 64'd16);
    spur_on_resp = 1'b0;
    n0 = n_resp;
    repeat (4) step();
    chk("spur_resp", 64'(n_resp), 64'(n0));
    single(3, 64'd5, 64'd5, 64'd25);

    // reset mid-WAIT
    req_mcand[2]  = rnd64();
    req_mplier[2] = rnd64();
    req_valid[2]  = 1'b1;
    n = 0;
    while (!infl_busy && n < 10) begin
      step();
      n++;
    end
    repeat (3) step();
    n0 = n_resp;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    mult_done = 1'b0;
    req_valid = '0;
    step();
    step();
    chk("rst_no_resp", 64'(n_resp), 64'(n0));
    reset_n = 1'b1;
    grant_q.delete();
    req_valid = 4'b0101;
    run_until_idle(200);
    chk("post_rst_first", 64'(qat(0)), 64'd0);
    chk("post_rst_second", 64'(qat(1)), 64'd2);

    // randomized traffic
    rand_lat = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_mcand[i]  = rnd64();
          req_mplier[i] = rnd64();
          req_valid[i]  = 1'b1;
        end
      end
      keep_mode = ($urandom_range(0, 3) == 0);
      step();
    end
    keep_mode = 1'b0;
    run_until_idle(600);
    rand_lat = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
